// File: rtl/sram_dualport_latency_n.sv
`default_nettype none
// ============================================================================
// Module   : sram_dualport_latency_n
// Brief    : Dual-port SRAM model with byte-lane writes, configurable read
//            latency, read-during-write policy and a read sideband tag.
//            Optional per-lane even parity when SRAM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sram_dualport_latency_n #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int LATENCY  = 3,
    parameter int RDW_MODE = 0,
    parameter int TAG_W    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wen_i,
    input  logic [WIDTH/8-1:0]       wbe_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     ren_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    input  logic [TAG_W-1:0]         rtag_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [TAG_W-1:0]         rtag_o,
    output logic                     vld_o,
    output logic                     err_o
);

    localparam int LANES = WIDTH / 8;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_same;
    logic [WIDTH-1:0] w_rd_word;
    logic [LANES-1:0] w_lane_err;
    logic             w_rd_err;

    // Addresses at or beyond DEPTH drop writes and read back as zero.
    assign w_wr_ok  = wen_i && ({1'b0, waddr_i} < c_DEPTH);
    assign w_rd_ok  = ({1'b0, raddr_i} < c_DEPTH);
    assign w_same   = w_wr_ok && (waddr_i == raddr_i);
    assign w_rd_err = |w_lane_err;

    // Each byte lane owns its own storage so lane enables map to independent
    // write ports, and the read-during-write bypass is decided per lane.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] w_old;
        logic       w_fwd;

        always_ff @(posedge clk_i) begin
            if (w_wr_ok && wbe_i[k]) begin
                r_mem[waddr_i] <= data_i[8*k +: 8];
            end
        end

        assign w_old = w_rd_ok ? r_mem[raddr_i] : 8'h00;
        assign w_fwd = (RDW_MODE == 1) && w_same && wbe_i[k];
        assign w_rd_word[8*k +: 8] = w_fwd ? data_i[8*k +: 8] : w_old;

`ifdef SRAM_PARITY_EN
        logic r_par [DEPTH];
        logic w_par;

        always_ff @(posedge clk_i) begin
            if (w_wr_ok && wbe_i[k]) begin
                r_par[waddr_i] <= ^data_i[8*k +: 8];
            end
        end

        // Forwarded bytes carry freshly computed parity, so only stored
        // (possibly corrupted) bytes can flag an error.
        assign w_par = w_fwd   ? ^data_i[8*k +: 8] :
                       w_rd_ok ? r_par[raddr_i]    : 1'b0;
        assign w_lane_err[k] = w_par ^ (^w_rd_word[8*k +: 8]);
`else
        assign w_lane_err[k] = 1'b0;
`endif
    end

    // Read pipeline: stage 0 is the array output register, stage LATENCY-1
    // drives the outputs. Payload stages only load behind a valid bit so the
    // outputs hold the last returned read while idle.
    logic [LATENCY-1:0] r_vld;
    logic [WIDTH-1:0]   r_data [LATENCY];
    logic [TAG_W-1:0]   r_tag  [LATENCY];
    logic [LATENCY-1:0] r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            r_vld[0] <= ren_i;
            if (ren_i) begin
                r_data[0] <= w_rd_word;
                r_tag[0]  <= rtag_i;
                r_err[0]  <= w_rd_err;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                    r_tag[i]  <= r_tag[i-1];
                    r_err[i]  <= r_err[i-1];
                end
            end
        end
    end

    assign data_o = r_data[LATENCY-1];
    assign rtag_o = r_tag[LATENCY-1];
    assign vld_o  = r_vld[LATENCY-1];
    assign err_o  = r_err[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_sram_dualport_latency_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_dualport_latency_n
// Brief    : Four differently configured SRAM instances share one stimulus
//            stream and are checked against a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_dualport_latency_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [3:0]  wbe;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [3:0]  raddr;
    logic [3:0]  rtag;

    logic [3:0][31:0] d_o;
    logic [3:0][3:0]  t_o;
    logic [3:0]       v_o;
    logic [3:0]       e_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instances: 0 = LAT3/RDW0, 1 = LAT1/RDW1, 2 = LAT5/DEPTH12, 3 = LAT4
    sram_dualport_latency_n #(.WIDTH(32), .DEPTH(16), .LATENCY(3), .RDW_MODE(0), .TAG_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .wbe_i(wbe), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rtag_i(rtag),
        .data_o(d_o[0]), .rtag_o(t_o[0]), .vld_o(v_o[0]), .err_o(e_o[0]));
    sram_dualport_latency_n #(.WIDTH(32), .DEPTH(16), .LATENCY(1), .RDW_MODE(1), .TAG_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .wbe_i(wbe), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rtag_i(rtag),
        .data_o(d_o[1]), .rtag_o(t_o[1]), .vld_o(v_o[1]), .err_o(e_o[1]));
    sram_dualport_latency_n #(.WIDTH(32), .DEPTH(12), .LATENCY(5), .RDW_MODE(0), .TAG_W(4)) dut_c (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .wbe_i(wbe), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rtag_i(rtag),
        .data_o(d_o[2]), .rtag_o(t_o[2]), .vld_o(v_o[2]), .err_o(e_o[2]));
    sram_dualport_latency_n #(.WIDTH(32), .DEPTH(16), .LATENCY(4), .RDW_MODE(0), .TAG_W(4)) dut_d (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .wbe_i(wbe), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .rtag_i(rtag),
        .data_o(d_o[3]), .rtag_o(t_o[3]), .vld_o(v_o[3]), .err_o(e_o[3]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int dep_of(input int k);
        return (k == 2) ? 12 : 16;
    endfunction

    function automatic bit rdw_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [4][16];
    logic [3:0]  m_bad [4][16];
    logic        s_v [4][32];
    logic [31:0] s_d [4][32];
    logic [3:0]  s_t [4][32];
    logic        s_e [4][32];
    logic        x_v [4];
    logic [31:0] x_d [4];
    logic [3:0]  x_t [4];
    logic        x_e [4];
    bit          armed = 1'b0;

    initial begin
        int          edge_n;
        int          sr;
        int          sc;
        logic [31:0] md;
        logic [3:0]  mb;
        edge_n = 0;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 32; s++) s_v[k][s] = 1'b0;
            for (int a = 0; a < 16; a++) m_bad[k][a] = 4'h0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rst) begin
                    for (int s = 0; s < 32; s++) s_v[k][s] = 1'b0;
                    x_v[k] = 1'b0; x_d[k] = 32'h0; x_t[k] = 4'h0; x_e[k] = 1'b0;
                end else begin
                    if (ren) begin
                        md = 32'h0;
                        mb = 4'h0;
                        if (int'(raddr) < dep_of(k)) begin
                            md = m_mem[k][raddr];
                            mb = m_bad[k][raddr];
                            if (rdw_of(k) && wen && waddr == raddr) begin
                                for (int l = 0; l < 4; l++) begin
                                    if (wbe[l]) begin
                                        md[8*l +: 8] = wdata[8*l +: 8];
                                        mb[l] = 1'b0;
                                    end
                                end
                            end
                        end
                        sr = (edge_n + lat_of(k) - 1) % 32;
                        s_v[k][sr] = 1'b1; s_d[k][sr] = md; s_t[k][sr] = rtag; s_e[k][sr] = |mb;
                    end
                    sc = edge_n % 32;
                    x_v[k] = s_v[k][sc];
                    if (s_v[k][sc]) begin
                        x_d[k] = s_d[k][sc]; x_t[k] = s_t[k][sc]; x_e[k] = s_e[k][sc];
                    end
                    s_v[k][sc] = 1'b0;
                end
                if (wen && int'(waddr) < dep_of(k)) begin
                    for (int l = 0; l < 4; l++) begin
                        if (wbe[l]) begin
                            m_mem[k][waddr][8*l +: 8] = wdata[8*l +: 8];
                            m_bad[k][waddr][l] = 1'b0;
                        end
                    end
                end
            end
            if (rst) armed = 1'b1;
            edge_n++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("u%0d_vld", k), {31'h0, v_o[k]}, {31'h0, x_v[k]});
                    chk($sformatf("u%0d_data", k), d_o[k], x_d[k]);
                    chk($sformatf("u%0d_tag", k), {28'h0, t_o[k]}, {28'h0, x_t[k]});
                    if (x_v[k]) chk($sformatf("u%0d_err", k), {31'h0, e_o[k]}, {31'h0, x_e[k]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic w, input logic [3:0] be, input logic [3:0] wa,
                         input logic [31:0] wd, input logic r, input logic [3:0] ra,
                         input logic [3:0] tg);
        wen = w; wbe = be; waddr = wa; wdata = wd; ren = r; raddr = ra; rtag = tg;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(1'b1, be, a, d, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] tg);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, tg);
        @(negedge clk);
    endtask

    // Called at the negedge after a read edge; waits for instance k's result.
    task automatic wait_vld(input int k, input logic [31:0] ed, input logic [3:0] et,
                            input logic ee, input string nm);
        int n;
        n = 0;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!v_o[k] && n < 20);
        chk({nm, "_vld"}, {31'h0, v_o[k]}, 32'h1);
        chk({nm, "_data"}, d_o[k], ed);
        chk({nm, "_tag"}, {28'h0, t_o[k]}, {28'h0, et});
        chk({nm, "_err"}, {31'h0, e_o[k]}, {31'h0, ee});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_u%0d_vld", k), {31'h0, v_o[k]}, 32'h0);
            chk($sformatf("rst_u%0d_data", k), d_o[k], 32'h0);
            chk($sformatf("rst_u%0d_tag", k), {28'h0, t_o[k]}, 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 16; i++) wr(4'(i), 32'(i), 4'hF);

        // Latency sweep: result exactly LATENCY edges after the read edge.
        wr(4'd2, 32'hA5A5_0001, 4'hF);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2, 4'h3);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("lat%0d_c%0d_vld", lat_of(k), c), {31'h0, v_o[k]},
                    (c == lat_of(k)) ? 32'h1 : 32'h0);
                if (c == lat_of(k)) begin
                    chk($sformatf("lat%0d_data", lat_of(k)), d_o[k], 32'hA5A5_0001);
                    chk($sformatf("lat%0d_tag", lat_of(k)), {28'h0, t_o[k]}, 32'h3);
                end
            end
            @(negedge clk);
            drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
        end

        // Byte lanes and the all-lanes-disabled no-op.
        wr(4'd5, 32'h1122_3344, 4'hF);
        wr(4'd5, 32'hFFFF_FFFF, 4'b0101);
        rd(4'd5, 4'h5);
        wait_vld(0, 32'h11FF_33FF, 4'h5, 1'b0, "byte_lane");
        wr(4'd5, 32'h0, 4'h0);
        rd(4'd5, 4'h6);
        wait_vld(0, 32'h11FF_33FF, 4'h6, 1'b0, "wbe_zero");

        // Read-during-write: instance 1 is write-first, instance 0 read-first.
        wr(4'd7, 32'h0, 4'hF);
        drive(1'b1, 4'hF, 4'd7, 32'hDEAD_BEEF, 1'b1, 4'd7, 4'h9);
        @(posedge clk);
        #1;
        chk("rdw_new_vld", {31'h0, v_o[1]}, 32'h1);
        chk("rdw_new_data", d_o[1], 32'hDEAD_BEEF);
        @(negedge clk);
        wait_vld(0, 32'h0000_0000, 4'h9, 1'b0, "rdw_old");
        drive(1'b1, 4'b0011, 4'd7, 32'h0, 1'b1, 4'd7, 4'hA);
        @(posedge clk);
        #1;
        chk("rdw_merge_data", d_o[1], 32'hDEAD_0000);
        @(negedge clk);
        wait_vld(0, 32'hDEAD_BEEF, 4'hA, 1'b0, "rdw_part_old");

        // Streaming on the LATENCY=4 instance.
        wr(4'd2, 32'd2, 4'hF);
        wr(4'd5, 32'd5, 4'hF);
        wr(4'd7, 32'd7, 4'hF);
        fork
            begin
                for (int i = 0; i < 8; i++) rd(4'(i), 4'(i));
                drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
            end
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!v_o[3] && n < 20);
                chk("stream_first_edge", 32'(n), 32'd4);
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("stream%0d_vld", i), {31'h0, v_o[3]}, 32'h1);
                    chk($sformatf("stream%0d_data", i), d_o[3], 32'(i));
                    chk($sformatf("stream%0d_tag", i), {28'h0, t_o[3]}, 32'(i));
                    @(posedge clk);
                    #1;
                end
                chk("stream_end_vld", {31'h0, v_o[3]}, 32'h0);
            end
        join
        @(negedge clk);

        // Reset with three reads in flight; write on the reset edge still lands.
        rd(4'd1, 4'h1);
        rd(4'd2, 4'h2);
        rd(4'd3, 4'h3);
        drive(1'b1, 4'hF, 4'd9, 32'h77, 1'b1, 4'd1, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_vld", c), {31'h0, v_o[3]}, 32'h0);
            chk($sformatf("post_rst%0d_data", c), d_o[3], 32'h0);
            @(negedge clk);
        end
        rd(4'd9, 4'h0);
        rd(4'd1, 4'h1);
        wait_vld(3, 32'h77, 4'h0, 1'b0, "rst_edge_write");
        idle(6);

        // Out of range on the DEPTH=12 instance.
        wr(4'd13, 32'h55, 4'hF);
        rd(4'd13, 4'h2);
        wait_vld(2, 32'h0, 4'h2, 1'b0, "oor_read");
        idle(2);
        for (int i = 0; i < 12; i++) rd(4'(i), 4'(i));
        idle(8);

`ifdef SRAM_PARITY_EN
        wr(4'd4, 32'h0000_00FF, 4'hF);
        idle(1);
        dut_a.g_lane[0].r_mem[4][0] = ~dut_a.g_lane[0].r_mem[4][0];
        m_mem[0][4][0] = ~m_mem[0][4][0];
        m_bad[0][4][0] = 1'b1;
        rd(4'd4, 4'h1);
        wait_vld(0, 32'h0000_00FE, 4'h1, 1'b1, "par_err");
        rd(4'd3, 4'h2);
        wait_vld(0, 32'h0000_0003, 4'h2, 1'b0, "par_clean");
        idle(4);
`endif

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_dualport_latency_n.md
Name: sram_dualport_latency_n

Overview:
Parametrised successor to the fixed-latency dual-port SRAM model used by the latency FIFOs. It has:
- one synchronous write port and one synchronous read port;
- a configurable read latency;
- byte-lane write enables;
- a selectable read-during-write policy;
- a sideband tag that travels with each read.

FIFO and cache wrappers use it as the storage element when they need a specific SRAM macro latency.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8.
DEPTH, 16, number of words; need not be a power of two.
ADDR_W, $clog2(DEPTH), address width.
LATENCY, 3, cycles from ren_i to vld_o; legal range 1..16.
RDW_MODE, 0, same-address read/write policy: 0 = read-first (old data), 1 = write-first (new data).
TAG_W, 4, width of the read sideband tag; must be at least 1.
LANES, WIDTH/8, number of byte lanes; derived, not overridden.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
wen_i  input  1  write enable
wbe_i  input  LANES  byte-lane write enables; lane k covers data bits [8k+7:8k]
waddr_i  input  ADDR_W  write address
data_i  input  WIDTH  write data
ren_i  input  1  read enable
raddr_i  input  ADDR_W  read address
rtag_i  input  TAG_W  tag captured with the read
data_o  output  WIDTH  read data
rtag_o  output  TAG_W  tag of the returned read
vld_o  output  1  data_o and rtag_o are valid this cycle
err_o  output  1  parity error on the returned word; qualified by vld_o

Behaviour:
- Single clock. Reset is synchronous and active-high on rst_i. Reset does not clear memory contents.
- Reset values:
  - vld_o = 0, err_o = 0, data_o = 0, rtag_o = 0.
  - All pipeline valid bits and pipeline data/tag/err registers clear to 0.
- Write: on a clock edge with wen_i=1 and waddr_i<DEPTH, each lane k with wbe_i[k]=1 is updated. Lanes with wbe_i[k]=0 are unchanged.
- Read: on a clock edge with ren_i=1, the word at raddr_i and rtag_i are captured. They appear on data_o/rtag_o with vld_o=1 exactly LATENCY cycles later.
  - Edge at cycle t gives vld_o high during cycle t+LATENCY.
  - LATENCY=1: outputs are driven straight from the array output register.
- Pipeline:
  - The valid bit shifts every cycle with no stall.
  - Data/tag/err stage i loads only when valid bit i is set. Outputs hold their last returned value while vld_o=0.
  - Back-to-back reads every cycle give one result per cycle, in order.
- Out-of-range addresses (index >= DEPTH):
  - Write is dropped.
  - Read returns data 0 with vld_o=1 and err_o=0.
- Read-during-write, same address and same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (new bytes in enabled lanes, old bytes elsewhere).
  - Different addresses: no interaction.
- Reset mid-operation: all in-flight reads are discarded, with no vld_o after reset. Writes on the reset edge are still performed. Reads on the reset edge are discarded.
- wen_i=1 with wbe_i=0: no-op.

Optional Feature:
SRAM_PARITY_EN
- Defined:
  - Each lane stores an extra even-parity bit, computed from the written byte on write.
  - On read, parity is rechecked per lane. err_o is the OR of all lane mismatches, pipelined alongside the data so it is aligned with vld_o.
  - A partial write recomputes parity only for the written lanes.
- Undefined: no parity storage; err_o is tied to 0.

Test Plan:
- Latency sweep:
  - Stimulus: LATENCY in {1,3,5}; write 0xA5A5_0001 to address 2, then read address 2 with tag 0x3.
  - Response: vld_o high exactly LATENCY cycles after the read edge; data_o=0xA5A5_0001; rtag_o=0x3; otherwise vld_o=0.
- Byte lanes:
  - Stimulus: write 0x1122_3344 to address 5, then write 0xFFFF_FFFF to address 5 with wbe_i=4'b0101, then read address 5.
  - Response: data_o=0x11FF_33FF.
- Read-during-write:
  - Stimulus: address 7 holds 0x0; on one edge, write 0xDEAD_BEEF (wbe_i all ones) and read address 7.
  - Response: RDW_MODE=0 returns 0x0000_0000; RDW_MODE=1 returns 0xDEAD_BEEF.
- Streaming and reset:
  - Stimulus: 8 back-to-back reads of addresses 0..7 (data = address), tags 0..7, LATENCY=4; then assert rst_i while 3 reads are in flight.
  - Response: the 8 results arrive in order on consecutive cycles; after the reset edge no vld_o pulse appears; memory still holds the prior data.
- Out of range:
  - Stimulus: DEPTH=12; write 0x55 to address 13, then read address 13.
  - Response: vld_o=1, data_o=0, err_o=0; addresses 0..11 are unchanged.
- Parity (SRAM_PARITY_EN defined):
  - Stimulus: write 0x0000_00FF; force-flip bit 0 of the stored word; read it back.
  - Response: err_o=1 with vld_o. A clean word returns err_o=0.
